sll_seq_shifter: RTL and testbench



---
 rtl/sll_seq_shifter_pkg.sv | 16 +
 rtl/sll_seq_shifter_stage.sv | 43 ++++
 rtl/sll_seq_shifter.sv | 108 ++++++++++
 tb/tb_sll_seq_shifter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/sll_seq_shifter_pkg.sv
// Shared definitions for the sequential shift-left-logical unit:
// default geometry, FSM state encoding and the last-stage index.
`timescale 1ns/1ps
package shifter_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int SHW_DEF    = 5;
    localparam int LAST_STAGE = SHW_DEF - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/sll_seq_shifter_stage.sv
// One shared barrel stage: shifts left by 2^stage with zero fill when
// enabled, otherwise passes the word through unchanged.
`timescale 1ns/1ps
module sll_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = SHW_DEF
) (
    input  logic [WIDTH-1:0] work_i,
    input  logic [SHW-1:0]   stage_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] work_o
);

    // Candidate result for every stage distance, one 2:1 mux per bit
    // with zero as the fill input for the low bits.
    logic [WIDTH-1:0] cand [SHW];

    for (genvar s = 0; s < SHW; s++) begin : g_stage
        for (genvar b = 0; b < WIDTH; b++) begin : g_bit
            if (b >= (1 << s)) begin : g_src
                assign cand[s][b] = work_i[b - (1 << s)];
            end else begin : g_fill
                assign cand[s][b] = 1'b0;
            end
        end
    end

    // Pick the candidate for the current stage; stage indices past the
    // last stage never occur during an operation and pass through.
    always_comb begin
        work_o = work_i;
        if (en_i) begin
            for (int s = 0; s < SHW; s++) begin
                if (stage_i == SHW'(s)) begin
                    work_o = cand[s];
                end
            end
        end
    end

endmodule

// File: rtl/sll_seq_shifter.sv
// Multi-cycle 32-bit shift-left-logical unit. Applies one barrel stage
// (1, 2, 4, 8, 16) per clock through a single shared stage mux, under a
// start/busy/done handshake. Latency is a fixed 6 cycles from start.
`timescale 1ns/1ps
module sll_seq_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,   // must be a power of two
    parameter int SHW   = SHW_DEF      // log2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res
);

    localparam int LAST = SHW - 1;

    state_e           state_q;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] work_d;
    logic [SHW-1:0]   shamt_q;
    logic [SHW-1:0]   stage_q;
    logic [WIDTH-1:0] res_q;
    logic             busy_q;
    logic             done_q;
    logic             stage_en;

    // Only the low SHW bits of the shift-amount source are meaningful.
    logic in2_unused;
    assign in2_unused = ^in2[WIDTH-1:SHW];

    // Select the shift-amount bit that controls the current stage.
    always_comb begin
        stage_en = 1'b0;
        for (int s = 0; s < SHW; s++) begin
            if (stage_q == SHW'(s)) begin
                stage_en = shamt_q[s];
            end
        end
    end

    sll_stage #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_stage (
        .work_i  (work_q),
        .stage_i (stage_q),
        .en_i    (stage_en),
        .work_o  (work_d)
    );

    // Control FSM plus datapath registers; busy/done are registered so
    // start has no combinational path to any output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            shamt_q <= '0;
            stage_q <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    // DONE accepts a new start exactly like IDLE so that
                    // operations can run back to back.
                    done_q <= 1'b0;
                    if (start) begin
                        work_q  <= in1;
                        shamt_q <= in2[SHW-1:0];
                        stage_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    work_q  <= work_d;
                    stage_q <= stage_q + SHW'(1);
                    if (stage_q == SHW'(LAST)) begin
                        res_q   <= work_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign res  = res_q;

endmodule

// File: tb/tb_sll_seq_shifter.sv
// Self-checking bench for sll_seq_shifter: directed cases, a mid-operation
// reset, a back-to-back handshake and randomized operations compared with
// a plain arithmetic shift model.
`timescale 1ns/1ps
module tb_sll_seq_shifter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        busy;
    logic        done;
    logic [31:0] res;

    int          checks;
    int          failures;
    logic [31:0] prev_res;

    sll_seq_shifter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .busy  (busy),
        .done  (done),
        .res   (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: shift left by the low five bits of the amount, zero fill.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        int n;
        n = int'(b % 32);
        return a << n;
    endfunction

    // Called at a falling edge with the unit idle or in its done cycle.
    // glitch_at selects a busy cycle (1..5) in which start is pulsed.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input int glitch_at, input string tag);
        logic [31:0] exp;
        exp   = model(a, b);
        in1   = a;
        in2   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        in1   = $urandom;
        in2   = $urandom;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_nodone"}, 32'(done), 32'd0);
            check({tag, "_hold"}, res, prev_res);
            if (j == glitch_at) begin
                start = 1'b1;
                in1   = $urandom;
                in2   = $urandom;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_idlebusy"}, 32'(busy), 32'd0);
        check({tag, "_res"}, res, exp);
        prev_res = exp;
    endtask

    task automatic idle(input int n, input string tag);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            check({tag, "_done0"}, 32'(done), 32'd0);
            check({tag, "_busy0"}, 32'(busy), 32'd0);
            check({tag, "_keep"}, res, prev_res);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        prev_res = 32'h0;
        rst_n    = 1'b0;
        start    = 1'b0;
        in1      = 32'h0;
        in2      = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_res", res, 32'h0);
        rst_n = 1'b1;
        idle(2, "post_rst");

        // Directed cases
        do_op(32'h0000_0001, 32'd31, 0, "msb");
        check("msb_const", res, 32'h8000_0000);
        idle(1, "gap1");
        do_op(32'hDEAD_BEEF, 32'd4, 0, "dead4");
        check("dead4_const", res, 32'hEADB_EEF0);
        idle(1, "gap2");
        do_op(32'hFFFF_FFFF, 32'h0000_0025, 0, "upper_ign");
        check("upper_const", res, 32'hFFFF_FFE0);
        idle(1, "gap3");
        do_op(32'h1234_5678, 32'd0, 0, "zero");
        check("zero_const", res, 32'h1234_5678);
        idle(2, "gap4");

        // Start ignored while busy, then start held in the done cycle
        do_op($urandom, $urandom, 2, "hs_first");
        do_op(32'h0000_00FF, 32'd8, 0, "hs_second");
        check("hs_const", res, 32'h0000_FF00);
        idle(2, "gap5");

        // Reset in the middle of an operation
        in1   = 32'hA5A5_A5A5;
        in2   = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_res", res, 32'h0);
        prev_res = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(8, "midrst_after");

        // Randomized operations, some back to back
        for (int i = 0; i < 20; i++) begin
            do_op($urandom, $urandom, int'($urandom_range(0, 5)), "rnd");
            if ($urandom_range(0, 1) == 1) begin
                idle(int'($urandom_range(1, 3)), "rnd_gap");
            end
        end
        idle(2, "tail");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
